// File: rtl/bcd_scan_display.sv
// bcd_scan_display: four-digit multiplexed seven-segment driver.
// Scans four BCD digits onto a common display, with leading-zero blanking
// and per-digit decimal points. Every output is registered.
module bcd_scan_display #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] digits,
    input  logic        blank_lz,
    input  logic [3:0]  dp_sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    // Smallest width that holds SCAN_DIV-1 (SCAN_DIV >= 2).
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic          tick;
    logic [3:0]    cur;
    logic [3:0]    blank;
    logic [6:0]    seg_d;

    assign tick = (pre == PW'(SCAN_DIV - 1));

    // Select the digit the scan currently points at.
    always_comb begin
        cur = 4'd0;
        case (idx)
            2'd0: cur = digits[3:0];
            2'd1: cur = digits[7:4];
            2'd2: cur = digits[11:8];
            2'd3: cur = digits[15:12];
            default: cur = 4'd0;
        endcase
    end

    // Leading-zero blanking: a digit blanks only while every digit above it
    // is a literal zero. Non-BCD codes are nonzero and stop the run.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = blank_lz && (digits[15:12] == 4'd0);
        blank[2] = blank[3] && (digits[11:8] == 4'd0);
        blank[1] = blank[2] && (digits[7:4] == 4'd0);
        blank[0] = 1'b0;
    end

    // BCD to {g,f,e,d,c,b,a}; codes above 9 show a dash on g.
    always_comb begin
        seg_d = 7'b1000000;
        case (cur)
            4'd0: seg_d = 7'b0111111;
            4'd1: seg_d = 7'b0000110;
            4'd2: seg_d = 7'b1011011;
            4'd3: seg_d = 7'b1001111;
            4'd4: seg_d = 7'b1100110;
            4'd5: seg_d = 7'b1101101;
            4'd6: seg_d = 7'b1111101;
            4'd7: seg_d = 7'b0000111;
            4'd8: seg_d = 7'b1111111;
            4'd9: seg_d = 7'b1101111;
            default: seg_d = 7'b1000000;
        endcase
        if (blank[idx]) seg_d = 7'b0000000;
    end

    // Prescaler, digit index and registered outputs. The output stage delays
    // every digit by the same edge, so each one still dwells SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            pre <= '0;
            idx <= 2'd0;
            seg <= 7'b0000000;
            dp  <= 1'b0;
            an  <= 4'b0000;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) idx <= idx + 2'd1;
            an  <= 4'b0001 << idx;
            seg <= seg_d;
            dp  <= dp_sel[idx];
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed bench for bcd_scan_display (SCAN_DIV = 4).
// Inputs change just after the falling edge; outputs are checked on the
// following falling edge, i.e. after exactly one rising edge.
module tb_bcd_scan_display;

    logic        clk;
    logic        clr;
    logic [15:0] digits;
    logic        blank_lz;
    logic [3:0]  dp_sel;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                           S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                           S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111,
                           S9 = 7'b1101111, SD = 7'b1000000, SB = 7'b0000000;

    logic [6:0] seg_tab [16];

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .digits   (digits),
        .blank_lz (blank_lz),
        .dp_sel   (dp_sel),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for sampling.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] e_an,
                           input logic [6:0] e_seg, input logic e_dp);
        chk({tag, " an"},  {12'd0, an},  {12'd0, e_an});
        chk({tag, " seg"}, {9'd0, seg},  {9'd0, e_seg});
        chk({tag, " dp"},  {15'd0, dp},  {15'd0, e_dp});
    endtask

    // One cycle of clr leaves pre = 0, idx = 0 and outputs cleared.
    task automatic do_reset();
        clr = 1'b1;
        step();
        chk_out("reset", 4'b0000, SB, 1'b0);
        clr = 1'b0;
    endtask

    // Checks one whole frame (16 edges) right after a reset.
    task automatic run_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] dpe);
        logic [6:0] es;
        for (int k = 0; k < 16; k++) begin
            step();
            case (k / 4)
                0: es = e0;
                1: es = e1;
                2: es = e2;
                default: es = e3;
            endcase
            chk_out(tag, 4'b0001 << (k / 4), es, dpe[k / 4]);
        end
    endtask

    initial begin
        seg_tab = '{S0, S1, S2, S3, S4, S5, S6, S7, S8, S9, SD, SD, SD, SD, SD, SD};

        // 1. Reset held 3 cycles, then scan order with wrap.
        clr = 1'b1; digits = 16'h1234; blank_lz = 1'b0; dp_sel = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("hold_clr", 4'b0000, SB, 1'b0);
        end
        clr = 1'b0;
        run_frame("scan", S4, S3, S2, S1, 4'b0000);
        step();
        chk_out("wrap", 4'b0001, S4, 1'b0);

        // 2. Decode sweep of digit 0, four codes per digit-0 dwell.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 4; j++) begin
                digits = {12'h123, 4'(g * 4 + j)};
                step();
                chk_out($sformatf("decode%0d", g * 4 + j), 4'b0001, seg_tab[g * 4 + j], 1'b0);
            end
            for (int j = 0; j < 12; j++) step();
        end

        // 3 + 4. Leading-zero blanking with decimal point on a blanked digit.
        blank_lz = 1'b1; dp_sel = 4'b0100; digits = 16'h0050;
        do_reset();
        run_frame("lz0050", S0, S5, SB, SB, 4'b0100);
        dp_sel = 4'b0000; digits = 16'h0000;
        do_reset();
        run_frame("lz0000", S0, SB, SB, SB, 4'b0000);
        digits = 16'h0A00;
        do_reset();
        run_frame("lz0A00", S0, S0, SD, SB, 4'b0000);

        // 5. Reset mid-dwell of digit 2 (an = 0100, pre = 2).
        blank_lz = 1'b0; digits = 16'h1234;
        do_reset();
        for (int i = 0; i < 10; i++) step();
        chk_out("pre_mid", 4'b0100, S2, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("mid_dwell", 4'b0001, S4, 1'b0);
        end
        step();
        chk_out("mid_next", 4'b0010, S3, 1'b0);

        // 5b. clr coincident with a tick: reset wins, idx restarts at 0.
        do_reset();
        for (int i = 0; i < 3; i++) step();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("tick_dwell", 4'b0001, S4, 1'b0);
        end
        step();
        chk_out("tick_next", 4'b0010, S3, 1'b0);

        // 6. Live change of digit 0 mid-dwell.
        digits = 16'h1232;
        do_reset();
        step();
        chk_out("live_a", 4'b0001, S2, 1'b0);
        step();
        chk_out("live_b", 4'b0001, S2, 1'b0);
        digits = 16'h1237;
        step();
        chk_out("live_c", 4'b0001, S7, 1'b0);
        step();
        chk_out("live_d", 4'b0001, S7, 1'b0);
        step();
        chk_out("live_e", 4'b0010, S3, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Four-digit multiplexed seven-segment driver that consumes the 4-bit BCD outputs of a chain of cascaded decade counters. It sits directly downstream of the counter stage and turns four parallel BCD digits into time-multiplexed segment and anode drive for a common 4-digit display. Internally it contains a scan prescaler, a digit-select counter, registered BCD-to-segment decode and leading-zero blanking.

## Interface

Parameters:
- SCAN_DIV, default 4: clock cycles each digit stays lit. Legal range is 2..65535.

Ports:
- clk, input, 1 bit: single clock; all state changes on the rising edge.
- clr, input, 1 bit: reset, synchronous, active-high.
- digits, input, 16 bits: four BCD digits. [3:0] is digit 0 (least significant); [15:12] is digit 3.
- blank_lz, input, 1 bit: when 1, blank leading zeros.
- dp_sel, input, 4 bits: decimal point enable per digit. Bit n belongs to digit n.
- seg, output, 7 bits: segment drive, active-high, ordered {g,f,e,d,c,b,a}.
- dp, output, 1 bit: decimal point drive, active-high.
- an, output, 4 bits: digit enable, one-hot, active-high. Bit n lights digit n.

## Operation

- **Prescaler `pre`:**
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - Its width is the minimum number of bits that holds SCAN_DIV-1.
  - The cycle where pre == SCAN_DIV-1 is the "tick".
- **Digit index `idx` (2 bits):**
  - Advances by 1 on each tick, in the order 0→1→2→3→0.
  - Holds its value on all other cycles.
- **Outputs:** registered every cycle from the current `idx` and the current inputs.
  - an <= 1 << idx.
  - seg <= decode of the selected digit, or 0 if that digit is blanked.
  - dp <= dp_sel[idx].
- **Decode table for seg {g..a}:**
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - Codes 10–15 (non-BCD) display 1000000, a dash on segment g only.
- **Leading-zero blanking:** applies only when blank_lz = 1.
  - Digit 3 is blank if d3 == 0.
  - Digit 2 is blank if d3 == 0 and d2 == 0.
  - Digit 1 is blank if d3, d2 and d1 are all 0.
  - Digit 0 is never blanked.
  - A non-BCD code counts as nonzero, so it stops blanking of the digits below it.
  - A blanked digit still drives its `an` bit, and dp still follows dp_sel.
- **clr:** overrides everything else, including a tick in the same cycle.
  - It sets pre = 0, idx = 0, seg = 0, dp = 0 and an = 0000.
  - Asserting clr in the middle of a frame abandons the scan immediately.
- **Inputs:** digits, blank_lz and dp_sel are sampled every cycle. No input is latched per frame.
  - A change on digits takes effect on the next edge if the affected digit is the one currently selected.

## Timing

- **Reset values:** seg = 0000000, dp = 0, an = 0000, pre = 0, idx = 0.
- **First lit cycle:** on the first edge with clr = 0, the outputs load an = 0001 and digit 0's decode.
- **Dwell:** each digit is lit for exactly SCAN_DIV consecutive cycles; a full frame is 4·SCAN_DIV cycles.
- **Input-to-output latency:** 1 clock from a change on `digits` of the selected digit to `seg`.
- **Digit changes:**
  - `idx` changes on the edge at the end of the tick cycle.
  - `an`/`seg` reflect the new digit one edge later.
  - The output pipeline stage is uniform, so every digit still gets exactly SCAN_DIV cycles.
- **an integrity:**
  - After the first post-reset edge, `an` always has exactly one bit set; all-zero occurs only while clr is applied.
  - `an` never has two bits set, and there is no blank gap between digits.
- **Clock:** no combinational path from inputs to outputs, and no multi-cycle paths.

## Test plan

All scenarios use SCAN_DIV = 4.

1. **Reset and scan order:** hold clr high for 3 cycles, then release; digits = 16'h1234, blank_lz = 0.
   - During clr: an = 0000, seg = 0.
   - After release: an = 0001 for 4 cycles with seg = 1100110 (4), then 0010 (3) ×4, 0100 (2) ×4, 1000 (1) ×4, then wraps to 0001.
2. **Full decode sweep:** step digit 0 through 0–15 while it is selected.
   - seg matches the table one cycle after each change.
   - Codes 10–15 give 1000000.
3. **Leading-zero blanking:** digits = 16'h0050, blank_lz = 1.
   - Digits 3 and 2 give seg = 0 with their `an` bit still asserted.
   - Digit 1 shows 5 (1101101); digit 0 shows 0 (0111111).
   - digits = 16'h0000 shows a single 0 on digit 0 only.
   - digits = 16'h0A00 blanks only digit 3.
4. **Decimal point:** dp_sel = 4'b0100.
   - dp = 1 exactly during the 4 cycles where an = 0100, and 0 otherwise, including on blanked digits.
5. **Reset mid-frame:** assert clr for 1 cycle while an = 0100 at pre = 2.
   - Next cycle: an = 0000.
   - Following edge: an = 0001, held for a full 4 cycles.
   - Also assert clr on a tick cycle: reset wins and idx = 0.
6. **Live input update:** change digits[3:0] from 2 to 7 in the middle of digit 0's dwell.
   - seg changes to 0000111 on the next edge.
   - The dwell length is unchanged at 4 cycles.
